add_share_arbiter: RTL and testbench
====================================

Name: add_share_arbiter

Overview:
- Shares one registered WIDTH-bit adder datapath (sum + carry-out) between NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready handshake; one result leaves per cycle on a single valid/ready response channel, tagged with the requester ID.
- Sits between the test-harness IN-bus slicing logic and the OUT-bus packing, replacing per-requester adders in fabric bring-up designs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand and sum width in bits.
- ID_W, $clog2(NUM_REQ), width of the requester ID tag (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot or zero; asserted only for the requester accepted this cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_sum  output  WIDTH  (A+B) mod 2^WIDTH.
- rsp_carry  output  1  carry-out of A+B.
- rsp_id  output  ID_W  index of the requester that produced this result.
- rsp_ready  input  1  downstream accepts the result this cycle.

Behaviour:
- Reset (rst=1 at posedge): rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, round-robin pointer=NUM_REQ-1, so requester 0 has top priority after reset. req_ready is combinational and reads 0 while rst=1.
- Reset mid-operation discards any held result without emitting it. Requesters whose valid stays high are re-arbitrated after reset.
- can_accept = !rsp_valid || rsp_ready (combinational). The block therefore supports full throughput of 1 op/cycle with no bubble.
- Grant (combinational):
  - When can_accept=1, grant the first i with req_valid[i]=1, searching from ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - When can_accept=0 or no request is pending, req_ready=0.
- Transfer on requester i: req_valid[i] && req_ready[i] at posedge. On a transfer:
  - {rsp_carry, rsp_sum} <= req_a_i + req_b_i, computed at WIDTH+1 bits and zero-extended.
  - rsp_id <= i; rsp_valid <= 1; ptr <= i.
- Latency: operands accepted at edge N produce rsp_valid=1 after edge N. The result is visible during cycle N+1.
- Response hold: while rsp_valid && !rsp_ready, rsp_sum, rsp_carry and rsp_id stay stable and no grant is issued.
- Drain without new transfer: rsp_valid && rsp_ready with no transfer clears rsp_valid <= 0. Data fields hold their last value.
- Simultaneous drain and accept: the result register is overwritten with the new result and rsp_valid stays 1.
- ptr changes only on a transfer. Idle cycles and stalls do not rotate priority.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NUM_REQ-1,0,... with no requester starved for more than NUM_REQ-1 grants.
- Requesters must hold req_valid and their operands until accepted. The block does not register unaccepted operands.
- Overflow example: 8'hFF + 8'h01 gives rsp_sum=8'h00, rsp_carry=1.
- Edge case: NUM_REQ not a power of two (e.g. 3) wraps from 2 to 0. rsp_id never exceeds NUM_REQ-1.

Decomposition:
- Package add_share_pkg holds:
  - the function computing ID_W from NUM_REQ (minimum 1);
  - localparam defaults DEF_NUM_REQ=4 and DEF_WIDTH=8.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr, enable. Output: one-hot gnt[N] plus an encoded gnt_id.
  - Purely combinational.
  - The parent owns ptr and the result register.

Test Plan:
- Reset check: assert rst for 2 cycles with all req_valid=1 -> req_ready=0 and rsp_valid=0 throughout. The first grant after release goes to requester 0.
- Single op: req 2 presents A=8'h3C, B=8'h05, rsp_ready=1 -> the cycle after acceptance shows rsp_valid=1, rsp_sum=8'h41, rsp_carry=0, rsp_id=2.
- Overflow: req 1 presents A=8'hFF, B=8'h01 -> rsp_sum=8'h00, rsp_carry=1, rsp_id=1.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1, 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, with rsp_valid=1 every cycle after the first.
- Backpressure: hold rsp_ready=0 for 3 cycles with requests pending -> req_ready=0, and rsp_* stay stable. On release, the held result drains and the next grant is accepted in the same cycle.
- Reset mid-flight: a result is held (rsp_valid=1, rsp_ready=0) and rst is pulsed for 1 cycle -> rsp_valid=0, the result is never emitted, and the next grant goes to requester 0.

Source files
------------

// File: rtl/add_share_pkg.sv
// add_share_pkg: shared defaults and ID-width helper for the shared adder arbiter
package add_share_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant searching upward from ptr+1
module rr_arbiter
    import add_share_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    localparam int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            enable,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);
    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (enable && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one registered adder shared round-robin between NUM_REQ requesters
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    localparam int ID_W   = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready
);
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             can_accept, xfer;
    logic [WIDTH:0]   add_res;

    assign can_accept = !rsp_valid_q || rsp_ready;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (can_accept && !rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign add_res   = {1'b0, req_a[int'(gnt_id)*WIDTH +: WIDTH]}
                     + {1'b0, req_b[int'(gnt_id)*WIDTH +: WIDTH]};

    // A drain with no new transfer clears valid but leaves the data fields untouched.
    always_comb begin
        rsp_valid_d = xfer ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_sum_d   = xfer ? add_res[WIDTH-1:0] : rsp_sum_q;
        rsp_carry_d = xfer ? add_res[WIDTH] : rsp_carry_q;
        rsp_id_d    = xfer ? gnt_id : rsp_id_q;
        ptr_d       = xfer ? gnt_id : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: directed stimulus with a round-robin reference model and result scoreboard
module tb_add_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_ready = 1'b0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
    logic [IW-1:0]  rsp_id;

    add_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          c;
        logic [W-1:0]  s;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   ids[$];
    int   mptr = N - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: check outputs at the negedge against the model, then advance past the posedge.
    task automatic step();
        logic [N-1:0] eg;
        logic [W:0]   r;
        bit           acc;
        int           gi;
        @(negedge clk);
        eg = '0;
        if (!rst) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                chk("rsp_sum", 32'(rsp_sum), 32'(sb[0].s));
                chk("rsp_carry", 32'(rsp_carry), 32'(sb[0].c));
            end
            acc = (sb.size() == 0) || rsp_ready;
            if (sb.size() != 0 && rsp_ready) begin
                ids.push_back(int'(sb[0].id));
                void'(sb.pop_front());
            end
            if (acc) begin
                for (int k = 1; k <= N; k++) begin
                    gi = (mptr + k) % N;
                    if (req_valid[gi]) begin
                        eg[gi] = 1'b1;
                        mptr   = gi;
                        r = {1'b0, req_a[gi*W +: W]} + {1'b0, req_b[gi*W +: W]};
                        sb.push_back('{id: IW'(gi), c: r[W], s: r[W-1:0]});
                        break;
                    end
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(eg));
        @(posedge clk);
        if (rst) begin
            sb.delete();
            mptr = N - 1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_op(i, W'(8'h10 * (i + 1)), W'(i + 3));
        rst = 1'b1;
        req_valid = '1;
        step();
        chk("rst_valid", 32'(rsp_valid), 0);
        step();
        chk("rst_valid2", 32'(rsp_valid), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("first_grant_id", 32'(rsp_id), 0);
        req_valid = '0;
        step();
        step();

        set_op(2, 8'h3C, 8'h05);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk("single_sum", 32'(rsp_sum), 32'h41);
        chk("single_carry", 32'(rsp_carry), 0);
        chk("single_id", 32'(rsp_id), 2);
        step();

        set_op(1, 8'hFF, 8'h01);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk("ovf_sum", 32'(rsp_sum), 32'h00);
        chk("ovf_carry", 32'(rsp_carry), 1);
        chk("ovf_id", 32'(rsp_id), 1);
        step();

        set_op(3, 8'h80, 8'h81);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();

        ids.delete();
        for (int i = 0; i < N; i++) set_op(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        req_valid = '1;
        for (int k = 0; k < 8; k++) step();
        req_valid = '0;
        step();
        chk("rr_count", 32'(ids.size()), 8);
        for (int k = 0; k < 8 && k < ids.size(); k++) chk("rr_seq", 32'(ids[k]), 32'(k % N));

        req_valid = '1;
        step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("bp_held_id", 32'(rsp_id), 0);
        rsp_ready = 1'b1;
        step();
        chk("bp_next_id", 32'(rsp_id), 1);
        chk("bp_valid", 32'(rsp_valid), 1);
        req_valid = '0;
        step();

        set_op(2, 8'hA5, 8'h5A);
        req_valid = 4'b0100;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        ids.delete();
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("midrst_no_emit", 32'(ids.size()), 0);
        chk("midrst_grant_id", 32'(rsp_id), 0);
        req_valid = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
